// File: rtl/float_mul_arbiter.sv
// -----------------------------------------------------------------------------
// float_mul_arbiter
//
// Shares one multi-cycle floating-point multiplier among NUM_PORTS requesters.
// Requests are served round-robin, one multiply in flight at a time. The
// result and a one-cycle ack pulse are returned to the port that was granted.
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous, active-high reset
//   req      per-port request, held by the requester until its ack
//   a, b     packed operands, port i at [i*FLOAT_WIDTH +: FLOAT_WIDTH]
//   ack      one-hot completion pulse, one cycle wide
//   out      multiply result, meaningful only while |ack
//   busy     high whenever the arbiter is not idle
//   grant    index of the port being served (meaningful while busy)
//   mul_req  single-cycle request to the shared multiplier
//   mul_a/b  registered operands to the multiplier, held until the next grant
//   mul_ack  multiplier completion pulse
//   mul_out  multiplier result, valid with mul_ack
// -----------------------------------------------------------------------------
module float_mul_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS*FLOAT_WIDTH-1:0] a,
  input  logic [NUM_PORTS*FLOAT_WIDTH-1:0] b,
  output logic [NUM_PORTS-1:0]             ack,
  output logic [FLOAT_WIDTH-1:0]           out,
  output logic                             busy,
  output logic [$clog2(NUM_PORTS)-1:0]     grant,
  output logic                             mul_req,
  output logic [FLOAT_WIDTH-1:0]           mul_a,
  output logic [FLOAT_WIDTH-1:0]           mul_b,
  input  logic                             mul_ack,
  input  logic [FLOAT_WIDTH-1:0]           mul_out
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          last_grant, last_grant_nxt;
  logic [GW-1:0]          grant_nxt;
  logic [NUM_PORTS-1:0]   ack_nxt;
  logic [FLOAT_WIDTH-1:0] out_nxt;
  logic                   busy_nxt;
  logic                   mul_req_nxt;
  logic [FLOAT_WIDTH-1:0] mul_a_nxt, mul_b_nxt;

  logic [GW:0]            pick;
  logic                   pick_found;
  logic [GW-1:0]          pick_idx;

  // Round-robin search: nearest set request after 'last', wrapping modulo
  // NUM_PORTS. Scanning from the farthest candidate down to the nearest lets
  // the nearest hit overwrite any farther one. Result is {found, index}.
  function automatic logic [GW:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                          input logic [GW-1:0]        last);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (r[idx]) res = {1'b1, GW'(idx)};
    end
    return res;
  endfunction

  assign pick       = rr_pick(req, last_grant);
  assign pick_found = pick[GW];
  assign pick_idx   = pick[GW-1:0];

  // Next-state and next-output logic. Every register has a default here so
  // that ack/out/mul_req fall back to zero and operands/grant simply hold.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    ack_nxt        = '0;
    out_nxt        = '0;
    mul_req_nxt    = 1'b0;
    mul_a_nxt      = mul_a;
    mul_b_nxt      = mul_b;

    case (state)
      IDLE: begin
        // Requests are only looked at here, so a port that is still holding
        // req during DONE cannot be served twice for one transaction.
        if (pick_found) begin
          grant_nxt      = pick_idx;
          last_grant_nxt = pick_idx;
          mul_a_nxt      = a[int'(pick_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
          mul_b_nxt      = b[int'(pick_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
          mul_req_nxt    = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // mul_ack is only honoured here; a late pulse from an operation that
        // was abandoned by reset arrives while IDLE and is dropped.
        if (mul_ack) begin
          out_nxt        = mul_out;
          ack_nxt[grant] = 1'b1;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_PORTS - 1);
      grant      <= '0;
      ack        <= '0;
      out        <= '0;
      busy       <= 1'b0;
      mul_req    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      ack        <= ack_nxt;
      out        <= out_nxt;
      busy       <= busy_nxt;
      mul_req    <= mul_req_nxt;
      mul_a      <= mul_a_nxt;
      mul_b      <= mul_b_nxt;
    end
  end

endmodule

// File: tb/tb_float_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_float_mul_arbiter
//
// Bench for float_mul_arbiter. A behavioural multiplier with programmable
// latency L answers mul_req. A transaction-level round-robin model predicts
// which port is granted, when, and the result; predictions go into a
// scoreboard queue that a negedge monitor drains as acks appear.
// -----------------------------------------------------------------------------
module tb_float_mul_arbiter;
  localparam int NP = 4;
  localparam int FW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req = '0;
  logic [NP*FW-1:0]  a = '0;
  logic [NP*FW-1:0]  b = '0;
  logic [NP-1:0]     ack;
  logic [FW-1:0]     out_w;
  logic              busy;
  logic [1:0]        grant;
  logic              mul_req;
  logic [FW-1:0]     mul_a;
  logic [FW-1:0]     mul_b;
  logic              mul_ack = 1'b0;
  logic [FW-1:0]     mul_out = 32'hDEADBEEF;

  always #5 clk = ~clk;

  float_mul_arbiter #(.NUM_PORTS(NP), .FLOAT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .ack(ack), .out(out_w),
    .busy(busy), .grant(grant), .mul_req(mul_req), .mul_a(mul_a),
    .mul_b(mul_b), .mul_ack(mul_ack), .mul_out(mul_out)
  );

  typedef struct {
    int          port;
    logic [31:0] res;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          glog[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          L = 5;
  int          want[NP];
  int          issued[NP];
  bit          fixed[NP];
  logic [31:0] fa[NP];
  logic [31:0] fb[NP];
  logic [31:0] last_out[NP];
  bit          hold = 1'b0;
  bit          scramble = 1'b0;
  bit          mbusy = 1'b0;
  int          mreq_cnt = 0;
  bit          prev_ack = 1'b0;

  // reference model state
  bit          m_idle = 1'b1;
  int          m_last = NP - 1;
  int          m_gcyc = 0;
  int          m_lat = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  // Truncating float multiply for normal numbers; zero exponent short-cuts
  // to a signed zero.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rnd_op();
    if ($urandom_range(7) == 0) return 32'h0;
    return {1'($urandom_range(1)), 8'(100 + $urandom_range(50)), 23'($urandom)};
  endfunction

  function automatic int log_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Transaction-level arbiter model: on an idle edge with requests pending,
  // the nearest requester after the previous winner is granted; the op then
  // occupies the arbiter for L+3 edges.
  always @(posedge clk) begin
    int p;
    cyc++;
    if (rst) begin
      m_idle = 1'b1;
      m_last = NP - 1;
      sbq.delete();
    end else if (!m_idle) begin
      if (cyc == m_gcyc + m_lat + 3) m_idle = 1'b1;
    end else if (req != '0) begin
      p = -1;
      for (int k = 1; k <= NP; k++)
        if (p < 0 && req[(m_last + k) % NP]) p = (m_last + k) % NP;
      m_idle = 1'b0;
      m_last = p;
      m_gcyc = cyc;
      m_lat  = L;
      m_a    = a[p*FW +: FW];
      m_b    = b[p*FW +: FW];
      sbq.push_back('{p, fmul(m_a, m_b), cyc, L});
    end
  end

  // Behavioural multiplier: sees mul_req, answers L+1 negedges later.
  initial begin
    logic [31:0] la, lb;
    forever begin
      @(negedge clk);
      if (mul_req && !rst) begin
        mbusy = 1'b1;
        la = mul_a;
        lb = mul_b;
        repeat (L + 1) @(negedge clk);
        mul_out = fmul(la, lb);
        mul_ack = 1'b1;
        @(negedge clk);
        mul_ack = 1'b0;
        mul_out = 32'hDEADBEEF;
        mbusy = 1'b0;
      end
    end
  end

  // Requesters: raise req for each outstanding op, drop it on ack.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++)
        if (req[p]) begin
          req[p] = 1'b0;
          issued[p]--;
        end
    end else if (!hold) begin
      for (int p = 0; p < NP; p++) begin
        if (req[p] && ack[p]) begin
          req[p] = 1'b0;
        end else if (!req[p] && issued[p] < want[p]) begin
          issued[p]++;
          a[p*FW +: FW] = fixed[p] ? fa[p] : rnd_op();
          b[p*FW +: FW] = fixed[p] ? fb[p] : rnd_op();
          req[p] = 1'b1;
        end else if (req[p] && scramble && busy && int'(grant) == p && $urandom_range(3) == 0) begin
          a[p*FW +: FW] = rnd_op();
          b[p*FW +: FW] = rnd_op();
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (rst) begin
      chk("rst_ack", {28'd0, ack}, 32'd0);
      chk("rst_out", out_w, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_mul_req", {31'd0, mul_req}, 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);
      prev_ack = 1'b0;
    end else begin
      if (mul_req) mreq_cnt++;
      chk("busy", {31'd0, busy}, {31'd0, !m_idle});
      if (!m_idle) begin
        chk("grant", {30'd0, grant}, 32'(m_last));
        chk("mul_req", {31'd0, mul_req}, {31'd0, cyc == m_gcyc});
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
      end else begin
        chk("mul_req_idle", {31'd0, mul_req}, 32'd0);
      end
      if (prev_ack) chk("ack_one_cycle", {28'd0, ack}, 32'd0);
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack=%b, required none (cycle %0d)", ack, cyc);
        end else begin
          e = sbq.pop_front();
          chk("ack_port", {28'd0, ack}, 32'(1 << e.port));
          chk("result", out_w, e.res);
          chk("latency", 32'(cyc), 32'(e.gcyc + e.lat + 2));
          last_out[e.port] = out_w;
        end
        idx = -1;
        for (int p = 0; p < NP; p++) if (ack[p] && idx < 0) idx = p;
        glog.push_back(idx);
      end else begin
        chk("out_idle", out_w, 32'd0);
        if (sbq.size() > 0 && cyc >= sbq[0].gcyc + sbq[0].lat + 2) begin
          checks++;
          failures++;
          $display("FAIL missing_ack: port %0d got no ack, required one by cycle %0d", sbq[0].port, sbq[0].gcyc + sbq[0].lat + 2);
          void'(sbq.pop_front());
        end
      end
      prev_ack = (ack != '0);
    end
  end

  task automatic wait_all_done(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      done = (req == '0) && m_idle && !mbusy;
      for (int p = 0; p < NP; p++) if (issued[p] != want[p]) done = 1'b0;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: not idle after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic set_op(input int p, input logic [31:0] x, input logic [31:0] y);
    fixed[p] = 1'b1;
    fa[p] = x;
    fb[p] = y;
  endtask

  initial begin
    int m0, n, g;
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      fixed[p] = 1'b0;
      fa[p] = '0;
      fb[p] = '0;
      last_out[p] = 32'hFFFFFFFF;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Ports 0 and 3 request together right after reset: 0 first, then 3.
    L = 5;
    set_op(0, 32'h3FC00000, 32'h3FC00000);
    set_op(3, 32'h3FC00000, 32'h3FC00000);
    want[0]++;
    want[3]++;
    wait_all_done(100, "t_simul");
    chk("t_simul_count", 32'(glog.size()), 32'd2);
    chk("t_simul_first", 32'(log_at(0)), 32'd0);
    chk("t_simul_second", 32'(log_at(1)), 32'd3);
    chk("t_simul_out0", last_out[0], 32'h40100000);
    chk("t_simul_out3", last_out[3], 32'h40100000);
    glog.delete();

    // Port 2 alone, L=5: 2.0 * 3.0, one mul_req pulse.
    set_op(2, 32'h40000000, 32'h40400000);
    m0 = mreq_cnt;
    want[2]++;
    wait_all_done(100, "t_single");
    chk("t_single_port", 32'(log_at(0)), 32'd2);
    chk("t_single_out", last_out[2], 32'h40C00000);
    chk("t_single_mul_req_pulses", 32'(mreq_cnt - m0), 32'd1);
    glog.delete();

    // Port 1 alone, L=1, zero operand.
    L = 1;
    set_op(1, 32'h00000000, 32'h41200000);
    want[1]++;
    wait_all_done(100, "t_zero");
    chk("t_zero_port", 32'(log_at(0)), 32'd1);
    chk("t_zero_out", last_out[1], 32'h00000000);
    glog.delete();

    // All four ports keep requesting: grants rotate 0,1,2,3 three times.
    reset_pulse();
    for (int p = 0; p < NP; p++) begin
      fixed[p] = 1'b0;
      want[p] += 3;
    end
    wait_all_done(400, "t_rr");
    chk("t_rr_count", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("t_rr_order%0d", i), 32'(log_at(i)), 32'(i % NP));
    glog.delete();

    // Port 0 re-requests while port 1 waits: 0, 1, 0.
    reset_pulse();
    L = 2;
    want[0] += 2;
    want[1] += 1;
    wait_all_done(200, "t_rereq");
    chk("t_rereq_count", 32'(glog.size()), 32'd3);
    chk("t_rereq_0", 32'(log_at(0)), 32'd0);
    chk("t_rereq_1", 32'(log_at(1)), 32'd1);
    chk("t_rereq_2", 32'(log_at(2)), 32'd0);
    glog.delete();

    // Reset while port 3 waits on the multiplier; the late mul_ack is ignored.
    L = 5;
    set_op(3, 32'h40000000, 32'h3FC00000);
    hold = 1'b0;
    want[3]++;
    n = 0;
    while (m_idle && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t_rst_granted", {31'd0, m_idle}, 32'd0);
    g = m_gcyc;
    n = 0;
    while (cyc < g + 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    hold = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (mbusy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t_rst_mul_done", {31'd0, mbusy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t_rst_no_ack", 32'(glog.size()), 32'd0);
    chk("t_rst_busy", {31'd0, busy}, 32'd0);
    chk("t_rst_out", out_w, 32'd0);
    hold = 1'b0;
    wait_all_done(100, "t_rst_retry");
    chk("t_rst_retry_port", 32'(log_at(0)), 32'd3);
    chk("t_rst_retry_out", last_out[3], 32'h40400000);
    glog.delete();

    // Randomised rounds with operand scrambling during service.
    scramble = 1'b1;
    for (int p = 0; p < NP; p++) fixed[p] = 1'b0;
    for (int r = 0; r < 6; r++) begin
      L = $urandom_range(1, 6);
      n = 0;
      for (int p = 0; p < NP; p++) begin
        m0 = $urandom_range(0, 3);
        want[p] += m0;
        n += m0;
      end
      wait_all_done(n * (L + 6) + 50, "t_random");
    end

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
